izh_spike_analyzer: RTL and testbench
=====================================

# izh_spike_analyzer

Downstream consumer of the Izhikevich neuron core's 8-bit membrane-voltage output (v1[17:10]: signed, 1 LSB = 1/64, 0.297 peak threshold ≈ 19, reset ≈ −32). It turns the voltage stream into spike events, inter-spike intervals (ISI), windowed spike rate and a burst flag. It sits between the neuron core and the readout/pin mux, and is clocked from the same clock as the core.

## Interface
Parameters:
- V_TH, 8'sd19: spike threshold. Spike when sample > V_TH.
- V_REARM, −8'sd16: re-arm level. Detector re-arms when sample ≤ V_REARM.
- WIN_LOG2, 10: rate window length, 2^WIN_LOG2 valid samples.
- ISI_W, 12: ISI counter width. Saturates at 2^ISI_W−1.
- BURST_ISI, 8: maximum ISI (samples) that still counts as intra-burst.
- BURST_MIN, 3: spikes needed to assert burst.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- v_in, in, 8: signed membrane-voltage sample.
- v_valid, in, 1: sample qualifier (driven by the core's ena). Every state update requires v_valid=1.
- clr, in, 1: synchronous soft clear. Same effect as reset, but in-cycle.
- spike, out, 1: one-cycle pulse per detected spike.
- isi, out, ISI_W: last ISI in samples.
- isi_valid, out, 1: one-cycle pulse when isi is updated.
- rate, out, 8: spikes in last complete window. Saturates at 255.
- rate_valid, out, 1: one-cycle pulse at window close.
- burst, out, 1: level. High while in a burst.

## Operation
- Detector FSM, two states:
  - ARMED (reset state): on a valid sample with v_in > V_TH, fire spike and go to REFRACT.
  - REFRACT: on a valid sample with v_in ≤ V_REARM, go to ARMED. Samples above V_TH in REFRACT do not fire.
  - All comparisons are signed.
- ISI counter (ISI_W bits, saturating):
  - Loaded with 1 on a spike sample.
  - Incremented on each other valid sample.
  - On a spike, isi ← counter value before the load, and isi_valid pulses, but only if have_prev=1. have_prev is set by the first spike.
  - Spikes at sample indices n and n+k report isi=k. A saturated counter reports 2^ISI_W−1.
- Rate:
  - win_cnt counts valid samples modulo 2^WIN_LOG2.
  - spk_cnt is 8 bits, saturating, and incremented per spike.
  - On the valid sample where win_cnt = 2^WIN_LOG2−1: rate ← spk_cnt plus that sample's spike (saturated), rate_valid pulses, and spk_cnt restarts at 0.
  - A spike on the closing sample is counted in the closing window.
- Burst:
  - burst_len is 3 bits, saturating.
  - On a spike with have_prev and ISI ≤ BURST_ISI: burst_len increments. Otherwise burst_len ← 1.
  - burst = (burst_len ≥ BURST_MIN).
  - When the ISI counter passes BURST_ISI without a spike, burst_len ← 0 and burst falls.
- Samples with v_valid=0 change no state and produce no pulses.
- clr or reset returns everything to reset values.
  - clr beats a simultaneous valid sample: that sample is discarded.
  - Reset asserted mid-window drops the partial rate without a rate_valid pulse.

## Timing
- All outputs are registered. Reset value of every output is 0, FSM=ARMED, have_prev=0, all counters 0.
- Latency: spike, isi/isi_valid, rate/rate_valid and burst update on the clock edge that accepts the sample. They are visible in the cycle after v_valid.
- Pulses last exactly one cycle, even under back-to-back valid samples.
- Back-to-back spikes need an intervening ≤ V_REARM sample, so the minimum ISI is 2.
- Spike and window close on the same sample: spike, rate_valid and (if eligible) isi_valid all pulse in the same cycle.

## Structure
- Package izh_pkg holds:
  - the detector state enum (ARMED, REFRACT);
  - shared fixed-point constants V_PEAK_Q=8'sd19 and V_RESET_Q=−8'sd32, also used by the neuron core;
  - the Q-format note (1 LSB = 1/64).
- One sub-module, izh_sat_counter: parameterised width, with load value, increment-enable and saturate. It is instantiated for the ISI, spk_cnt and burst_len counters.

## Test plan
- Single spike: v_in=−32 for 5 valid samples, then 25, then −32. Required: spike one cycle after the 25 sample, isi_valid=0, burst=0.
- ISI and refractory:
  - Spikes (v_in=25) at valid indices 10 and 17, with −32 elsewhere → isi=7 with isi_valid pulse at the second spike.
  - A 25,25 pair without re-arm → only one spike.
- Gapped valid: the same stream with v_valid=0 inserted on random cycles → identical outputs, time-shifted only.
- Rate window: WIN_LOG2=4, spikes at indices 3, 7 and 15 → at index 15, rate=3 and rate_valid pulses. The next window starts at 0.
- Burst: spikes with ISIs 4,4 → burst rises on the 3rd spike. Then 9 quiet samples → burst falls. An ISI of 20 → burst_len=1.
- Reset/clr:
  - rst_n low mid-window with v_valid=1 → all outputs 0 immediately.
  - clr coincident with a 25 sample → no spike, and state is ARMED.

Source files
------------

// File: rtl/izh_pkg.sv
// Shared fixed-point constants and detector state type for the Izhikevich
// neuron core and its downstream spike analyzer.
package izh_pkg;

    // Membrane voltage samples are signed 8-bit, 1 LSB = 1/64.
    localparam logic signed [7:0] V_PEAK_Q  = 8'sd19;
    localparam logic signed [7:0] V_RESET_Q = -8'sd32;

    typedef enum logic {
        ARMED   = 1'b0,
        REFRACT = 1'b1
    } det_state_t;

endpackage

// File: rtl/izh_spike_analyzer_if.sv
// Sample stream in, spike/ISI/rate/burst results out.
interface izh_spike_analyzer_if #(
    parameter int ISI_W = 12
);
    logic signed [7:0] v_in;
    logic              v_valid;
    logic              clr;
    logic              spike;
    logic [ISI_W-1:0]  isi;
    logic              isi_valid;
    logic [7:0]        rate;
    logic              rate_valid;
    logic              burst;

    modport master (
        output v_in, v_valid, clr,
        input  spike, isi, isi_valid, rate, rate_valid, burst
    );

    modport slave (
        input  v_in, v_valid, clr,
        output spike, isi, isi_valid, rate, rate_valid, burst
    );
endinterface

// File: rtl/izh_sat_counter.sv
// Saturating up-counter with synchronous clear and parallel load.
// Priority: clear, then load, then increment.
module izh_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (load_i)
            cnt_d = load_val_i;
        else if (inc_i && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/izh_spike_analyzer.sv
// Turns the neuron core voltage stream into spike pulses, inter-spike
// intervals, windowed spike rate and a burst level.
//   state   | meaning
//   ARMED   | waiting for a sample above V_TH
//   REFRACT | spike fired, waiting for a sample at or below V_REARM
module izh_spike_analyzer
    import izh_pkg::*;
#(
    parameter logic signed [7:0] V_TH      = V_PEAK_Q,
    parameter logic signed [7:0] V_REARM   = V_RESET_Q >>> 1,
    parameter int                WIN_LOG2  = 10,
    parameter int                ISI_W     = 12,
    parameter int                BURST_ISI = 8,
    parameter int                BURST_MIN = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    izh_spike_analyzer_if.slave  bus
);
    localparam logic [ISI_W-1:0] BURST_ISI_C = ISI_W'(BURST_ISI);
    localparam logic [3:0]       BURST_MIN_C = 4'(BURST_MIN);

    det_state_t          state_q, state_d;
    logic                accept, fire, close, intra, isi_elig, quiet;
    logic [ISI_W-1:0]    isi_cnt, isi_q;
    logic [7:0]          spk_cnt, rate_q;
    logic [2:0]          burst_len;
    logic [WIN_LOG2-1:0] win_q;
    logic                have_prev_q, spike_q, isi_valid_q, rate_valid_q;
    logic                burst_q, burst_d;

    // A clear discards whatever sample arrives with it.
    assign accept   = bus.v_valid & ~bus.clr;
    assign fire     = accept && (state_q == ARMED) && (bus.v_in > V_TH);
    assign close    = accept && (win_q == '1);
    assign intra    = have_prev_q && (isi_cnt <= BURST_ISI_C);
    assign isi_elig = fire & have_prev_q;
    assign quiet    = accept && !fire && (isi_cnt == BURST_ISI_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ARMED;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.clr) begin
            state_d = ARMED;
        end else if (accept) begin
            case (state_q)
                ARMED:   if (bus.v_in > V_TH)     state_d = REFRACT;
                REFRACT: if (bus.v_in <= V_REARM) state_d = ARMED;
                default: state_d = ARMED;
            endcase
        end
    end

    izh_sat_counter #(.W(ISI_W)) u_isi_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (bus.clr),
        .load_i     (fire),
        .load_val_i (ISI_W'(1)),
        .inc_i      (accept & ~fire),
        .cnt_o      (isi_cnt)
    );

    izh_sat_counter #(.W(8)) u_spk_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (bus.clr),
        .load_i     (close),
        .load_val_i (8'd0),
        .inc_i      (fire),
        .cnt_o      (spk_cnt)
    );

    izh_sat_counter #(.W(3)) u_burst_len (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (bus.clr | quiet),
        .load_i     (fire & ~intra),
        .load_val_i (3'd1),
        .inc_i      (fire & intra),
        .cnt_o      (burst_len)
    );

    // Burst level tracks the burst_len value being written this cycle so it
    // stays a plain flop output; the 4-bit sum keeps the saturated case high.
    always_comb begin
        burst_d = burst_q;
        if (bus.clr || quiet)
            burst_d = 1'b0;
        else if (fire)
            burst_d = intra ? (({1'b0, burst_len} + 4'd1) >= BURST_MIN_C)
                            : (BURST_MIN <= 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_prev_q  <= 1'b0;
            win_q        <= '0;
            isi_q        <= '0;
            rate_q       <= '0;
            spike_q      <= 1'b0;
            isi_valid_q  <= 1'b0;
            rate_valid_q <= 1'b0;
            burst_q      <= 1'b0;
        end else begin
            spike_q      <= fire;
            isi_valid_q  <= isi_elig;
            rate_valid_q <= close;
            burst_q      <= burst_d;
            if (bus.clr) begin
                have_prev_q <= 1'b0;
                win_q       <= '0;
                isi_q       <= '0;
                rate_q      <= '0;
            end else begin
                if (fire)
                    have_prev_q <= 1'b1;
                if (accept)
                    win_q <= win_q + 1'b1;
                if (isi_elig)
                    isi_q <= isi_cnt;
                if (close)
                    rate_q <= (fire && (spk_cnt != 8'hFF)) ? spk_cnt + 8'd1 : spk_cnt;
            end
        end
    end

    assign bus.spike      = spike_q;
    assign bus.isi        = isi_q;
    assign bus.isi_valid  = isi_valid_q;
    assign bus.rate       = rate_q;
    assign bus.rate_valid = rate_valid_q;
    assign bus.burst      = burst_q;
endmodule

// File: tb/tb_izh_spike_analyzer.sv
// Directed bench for izh_spike_analyzer with a 16-sample rate window.
module tb_izh_spike_analyzer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    izh_spike_analyzer_if #(.ISI_W(12)) bus ();

    izh_spike_analyzer #(.WIN_LOG2(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_spike"}, bus.spike, 0);
        chk({tag, "_isi"}, bus.isi, 0);
        chk({tag, "_isi_valid"}, bus.isi_valid, 0);
        chk({tag, "_rate"}, bus.rate, 0);
        chk({tag, "_rate_valid"}, bus.rate_valid, 0);
        chk({tag, "_burst"}, bus.burst, 0);
    endtask

    // Drive one cycle and sample outputs 1 time unit after the edge.
    task automatic step(input logic signed [7:0] v, input logic vld, input logic c);
        bus.v_in    = v;
        bus.v_valid = vld;
        bus.clr     = c;
        @(posedge clk);
        #1;
    endtask

    // Spikes at valid indices 10 and 17, optionally with idle cycles mixed in.
    task automatic isi_stream(input bit gap);
        for (int i = 0; i < 18; i++) begin
            if (gap && ($urandom_range(0, 2) == 0)) begin
                step(8'sd25, 1'b0, 1'b0);
                chk("gap_spike", bus.spike, 0);
                chk("gap_isi_valid", bus.isi_valid, 0);
                chk("gap_rate_valid", bus.rate_valid, 0);
            end
            step((i == 10 || i == 17) ? 8'sd25 : -8'sd32, 1'b1, 1'b0);
            if (i == 10) begin
                chk("isi_first_spike", bus.spike, 1);
                chk("isi_first_valid", bus.isi_valid, 0);
            end
            if (i == 15) begin
                chk("isi_win_rate_valid", bus.rate_valid, 1);
                chk("isi_win_rate", bus.rate, 1);
            end
            if (i == 17) begin
                chk("isi_second_spike", bus.spike, 1);
                chk("isi_second_valid", bus.isi_valid, 1);
                chk("isi_value", bus.isi, 7);
                chk("isi_no_burst", bus.burst, 0);
            end
        end
        step(8'sd25, 1'b0, 1'b0);
        chk("isi_hold_value", bus.isi, 7);
        chk("isi_pulse_drop", bus.isi_valid, 0);
        chk("isi_spike_drop", bus.spike, 0);
    endtask

    initial begin
        bus.v_in    = 8'sd0;
        bus.v_valid = 1'b0;
        bus.clr     = 1'b0;
        #12;
        chk_zero("reset");
        rst_n = 1'b1;

        // Single spike
        for (int i = 0; i < 5; i++) step(-8'sd32, 1'b1, 1'b0);
        step(8'sd25, 1'b1, 1'b0);
        chk("single_spike", bus.spike, 1);
        chk("single_isi_valid", bus.isi_valid, 0);
        chk("single_burst", bus.burst, 0);
        step(-8'sd32, 1'b1, 1'b0);
        chk("single_spike_drop", bus.spike, 0);

        // ISI stream, contiguous then gapped
        step(8'sd0, 1'b1, 1'b1);
        chk("clr_spike", bus.spike, 0);
        isi_stream(1'b0);
        step(8'sd0, 1'b1, 1'b1);
        chk("clr_isi", bus.isi, 0);
        isi_stream(1'b1);

        // Threshold and re-arm boundaries, refractory pair
        step(8'sd0, 1'b1, 1'b1);
        step(8'sd19, 1'b1, 1'b0);
        chk("th_at_19", bus.spike, 0);
        step(8'sd20, 1'b1, 1'b0);
        chk("th_at_20", bus.spike, 1);
        step(8'sd25, 1'b1, 1'b0);
        chk("refract_pair", bus.spike, 0);
        step(-8'sd15, 1'b1, 1'b0);
        step(8'sd25, 1'b1, 1'b0);
        chk("rearm_m15", bus.spike, 0);
        step(-8'sd16, 1'b1, 1'b0);
        step(8'sd25, 1'b1, 1'b0);
        chk("rearm_m16", bus.spike, 1);

        // Rate window: spikes at 3, 7, 15, then an empty window
        step(8'sd0, 1'b1, 1'b1);
        for (int i = 0; i < 32; i++) begin
            step((i == 3 || i == 7 || i == 15) ? 8'sd25 : -8'sd32, 1'b1, 1'b0);
            if (i == 7) chk("rate_isi4", bus.isi, 4);
            if (i == 14) chk("rate_no_close", bus.rate_valid, 0);
            if (i == 15) begin
                chk("rate_close_spike", bus.spike, 1);
                chk("rate_close_valid", bus.rate_valid, 1);
                chk("rate_close_value", bus.rate, 3);
                chk("rate_isi8", bus.isi, 8);
                chk("rate_isi8_valid", bus.isi_valid, 1);
                chk("rate_burst_isi8", bus.burst, 1);
            end
            if (i == 16) chk("rate_valid_drop", bus.rate_valid, 0);
            if (i == 22) chk("rate_burst_hold", bus.burst, 1);
            if (i == 24) chk("rate_burst_fall", bus.burst, 0);
            if (i == 31) begin
                chk("rate_empty_valid", bus.rate_valid, 1);
                chk("rate_empty_value", bus.rate, 0);
            end
        end

        // Burst: ISIs 4,4 then quiet, then ISI 20 restarts at length 1
        step(8'sd0, 1'b1, 1'b1);
        for (int i = 0; i < 37; i++) begin
            step((i == 0 || i == 4 || i == 8 || i == 28 || i == 32 || i == 36)
                 ? 8'sd25 : -8'sd32, 1'b1, 1'b0);
            if (i == 4)  chk("burst_2nd", bus.burst, 0);
            if (i == 8)  chk("burst_3rd", bus.burst, 1);
            if (i == 15) chk("burst_quiet7", bus.burst, 1);
            if (i == 17) chk("burst_quiet9", bus.burst, 0);
            if (i == 28) begin
                chk("burst_isi20", bus.isi, 20);
                chk("burst_isi20_valid", bus.isi_valid, 1);
                chk("burst_isi20_level", bus.burst, 0);
            end
            if (i == 32) chk("burst_len2", bus.burst, 0);
            if (i == 36) chk("burst_len3", bus.burst, 1);
        end

        // ISI saturation
        for (int i = 0; i < 4100; i++) step(-8'sd32, 1'b1, 1'b0);
        step(8'sd25, 1'b1, 1'b0);
        chk("isi_sat", bus.isi, 4095);
        chk("isi_sat_valid", bus.isi_valid, 1);

        // Asynchronous reset mid-window with a valid spike sample present
        bus.v_in    = 8'sd25;
        bus.v_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step((i == 2) ? 8'sd25 : -8'sd32, 1'b1, 1'b0);
            if (i == 14) chk("post_rst_no_close", bus.rate_valid, 0);
            if (i == 15) begin
                chk("post_rst_close", bus.rate_valid, 1);
                chk("post_rst_rate", bus.rate, 1);
            end
        end

        // clr beats a coincident spike sample and leaves the detector armed
        step(-8'sd32, 1'b1, 1'b0);
        step(8'sd25, 1'b1, 1'b1);
        chk("clr_coincident", bus.spike, 0);
        step(8'sd25, 1'b1, 1'b0);
        chk("clr_then_armed", bus.spike, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
